// File: rtl/thermometer_encoder_5bit.sv
// rtl/thermometer_encoder_5bit.sv - slew-limited binary-to-thermometer encoder for DCO tuning
module thermometer_encoder_5bit #(
  parameter int STEP       = 1,
  parameter int RESET_CODE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  code_in,
  input  logic        code_valid,
  output logic        code_ready,
  input  logic        hold,
  output logic [31:0] therm_out,
  output logic [4:0]  cur_code,
  output logic        busy,
  output logic        settled
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLEW = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0]        RST_CODE = 5'(RESET_CODE);
  localparam logic [4:0]        STEP_U   = 5'(STEP);
  localparam logic signed [6:0] STEP_S   = 7'(STEP);

  state_t            state;
  state_t            next_state;
  logic [4:0]        target_q;
  logic [4:0]        next_target;
  logic [4:0]        next_code;
  logic signed [6:0] diff;
  logic signed [6:0] mag;
  logic              accept;
  logic              close;

  // bit i is set exactly when i < c, so code 31 leaves bit 31 clear
  function automatic logic [31:0] therm_decode(input logic [4:0] c);
    logic [31:0] t;
    for (int i = 0; i < 32; i++) begin
      t[i] = (i < int'(c));
    end
    return t;
  endfunction

  // signed distance to target; 7 bits so the negation of -31 cannot wrap
  always_comb begin
    accept = code_valid && (state == IDLE);
    diff   = $signed({2'b00, target_q}) - $signed({2'b00, cur_code});
    mag    = (diff < 0) ? -diff : diff;
    close  = (mag <= STEP_S);
  end

  // state register plus code/target/thermometer registers, all on one edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_code  <= RST_CODE;
      therm_out <= therm_decode(RST_CODE);
      target_q  <= RST_CODE;
    end else begin
      state     <= next_state;
      cur_code  <= next_code;
      therm_out <= therm_decode(next_code);
      target_q  <= next_target;
    end
  end

  // next-state logic; hold only matters while slewing
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = (code_in == cur_code) ? DONE : SLEW;
        end
      end
      SLEW: begin
        if (!hold && close) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // next code: snap to target when within one step, otherwise move one full step
  always_comb begin
    next_code   = cur_code;
    next_target = target_q;
    if (state == IDLE && accept) begin
      next_target = code_in;
    end
    if (state == SLEW && !hold) begin
      if (close) begin
        next_code = target_q;
      end else if (diff > 0) begin
        next_code = cur_code + STEP_U;
      end else begin
        next_code = cur_code - STEP_U;
      end
    end
  end

  // handshake and status outputs decoded from the state register
  always_comb begin
    code_ready = (state == IDLE);
    busy       = (state != IDLE);
    settled    = (state == DONE);
  end

endmodule

// File: tb/tb_thermometer_encoder_5bit.sv
// tb/tb_thermometer_encoder_5bit.sv - self-checking bench for thermometer_encoder_5bit
module tb_thermometer_encoder_5bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        cv;
  logic        hold;
  logic        sel;
  logic [4:0]  code_in;
  logic        cv1, cv4;
  logic        r1, b1, s1, r4, b4, s4;
  logic [31:0] t1, t4;
  logic [4:0]  c1, c4;
  logic        rdy_v, busy_v, set_v;
  logic [31:0] therm_v;
  logic [4:0]  cur_v;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign cv1     = cv & ~sel;
  assign cv4     = cv & sel;
  assign rdy_v   = sel ? r4 : r1;
  assign busy_v  = sel ? b4 : b1;
  assign set_v   = sel ? s4 : s1;
  assign therm_v = sel ? t4 : t1;
  assign cur_v   = sel ? c4 : c1;

  thermometer_encoder_5bit #(.STEP(1), .RESET_CODE(16)) u1 (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(cv1), .code_ready(r1),
    .hold(hold), .therm_out(t1), .cur_code(c1), .busy(b1), .settled(s1)
  );

  thermometer_encoder_5bit #(.STEP(4), .RESET_CODE(16)) u4 (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(cv4), .code_ready(r4),
    .hold(hold), .therm_out(t4), .cur_code(c4), .busy(b4), .settled(s4)
  );

  typedef struct {
    bit          sel;
    logic [4:0]  code;
    int          hold_after;
    int          hold_len;
    logic [4:0]  noise;
    int          exp_edges;
    logic [31:0] exp_therm;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dec(input int c);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < c; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic run_move(input vec_t v);
    logic [4:0]  start;
    logic [4:0]  prev_c;
    logic [31:0] prev_t;
    int          d, s, n, sgn, edges, e;
    int          q[$];
    sel = v.sel;
    #1;
    start = cur_v;
    s     = v.sel ? 4 : 1;
    d     = int'(v.code) - int'(start);
    sgn   = (d < 0) ? -1 : 1;
    n     = ((d < 0 ? -d : d) + s - 1) / s;
    for (int k = 1; k <= n; k++) begin
      q.push_back((k == n) ? int'(v.code) : int'(start) + sgn * k * s);
    end
    check("ready_before_accept", 32'(rdy_v), 32'd1);
    code_in = v.code;
    cv = 1'b1;
    tick();
    cv = 1'b0;
    if (n == 0) begin
      check("equal_settled", 32'(set_v), 32'd1);
      check("equal_therm", therm_v, dec(int'(start)));
    end else begin
      check("accept_busy", 32'(busy_v), 32'd1);
      check("accept_no_change", 32'(cur_v), 32'(start));
    end
    edges = 0;
    while (!set_v && edges < 80) begin
      if (edges == v.hold_after && v.hold_len > 0) begin
        prev_c = cur_v;
        prev_t = therm_v;
        hold = 1'b1;
        for (int h = 0; h < v.hold_len; h++) begin
          if (h == 1) begin
            cv = 1'b1;
            code_in = v.noise;
          end
          tick();
          cv = 1'b0;
          check("hold_code", 32'(cur_v), 32'(prev_c));
          check("hold_therm", therm_v, prev_t);
          check("hold_busy", 32'(busy_v), 32'd1);
        end
        hold = 1'b0;
        code_in = v.code;
      end
      tick();
      edges++;
      if (q.size() == 0) begin
        check("extra_edge", 32'(edges), 32'(n));
        break;
      end
      e = q.pop_front();
      check("slew_code", 32'(cur_v), 32'(e));
      check("slew_therm", therm_v, dec(e));
    end
    check("settle_edges", 32'(edges), 32'(v.exp_edges));
    check("settled_pulse", 32'(set_v), 32'd1);
    check("final_therm", therm_v, v.exp_therm);
    check("final_ones", 32'($countones(therm_v)), 32'(v.code));
    check("queue_left", 32'(q.size()), 32'd0);
    tick();
    check("settled_one_cycle", 32'(set_v), 32'd0);
    check("ready_after_done", 32'(rdy_v), 32'd1);
  endtask

  initial begin
    vec_t v;
    logic [4:0] st;
    int dd;

    vecs[0] = '{1'b0, 5'd20, -1, 0, 5'd0,  4, 32'h000F_FFFF};
    vecs[1] = '{1'b0, 5'd20, -1, 0, 5'd0,  0, 32'h000F_FFFF};
    vecs[2] = '{1'b0, 5'd17, -1, 0, 5'd0,  3, 32'h0001_FFFF};
    vecs[3] = '{1'b0, 5'd25,  3, 3, 5'd2,  8, 32'h01FF_FFFF};
    vecs[4] = '{1'b1, 5'd0,  -1, 0, 5'd0,  4, 32'h0000_0000};
    vecs[5] = '{1'b1, 5'd31, -1, 0, 5'd0,  8, 32'h7FFF_FFFF};
    vecs[6] = '{1'b1, 5'd29, -1, 0, 5'd0,  1, 32'h1FFF_FFFF};
    vecs[7] = '{1'b1, 5'd3,   2, 2, 5'd30, 7, 32'h0000_0007};
    vecs[8] = '{1'b1, 5'd3,  -1, 0, 5'd0,  0, 32'h0000_0007};

    rst = 1'b1; cv = 1'b0; hold = 1'b0; sel = 1'b0; code_in = 5'd0;
    tick();
    rst = 1'b0;
    check("rst_therm1", t1, 32'h0000_FFFF);
    check("rst_code1", 32'(c1), 32'd16);
    check("rst_ready1", 32'(r1), 32'd1);
    check("rst_busy1", 32'(b1), 32'd0);
    check("rst_settled1", 32'(s1), 32'd0);
    check("rst_therm4", t4, 32'h0000_FFFF);
    check("rst_ready4", 32'(r4), 32'd1);

    for (int i = 0; i < 9; i++) run_move(vecs[i]);

    // reset in the middle of a slew (u1 sits at 25)
    sel = 1'b0; code_in = 5'd5; cv = 1'b1;
    tick();
    cv = 1'b0;
    tick();
    tick();
    check("midslew_code", 32'(c1), 32'd23);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_code", 32'(c1), 32'd16);
    check("midrst_therm", t1, 32'h0000_FFFF);
    check("midrst_busy", 32'(b1), 32'd0);
    check("midrst_ready", 32'(r1), 32'd1);
    check("midrst_code4", 32'(c4), 32'd16);

    // reset wins over a simultaneous accept
    code_in = 5'd3; cv = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; cv = 1'b0;
    check("rstacc_code", 32'(c1), 32'd16);
    check("rstacc_busy", 32'(b1), 32'd0);
    tick();
    check("rstacc_idle", 32'(b1), 32'd0);
    check("rstacc_hold_code", 32'(c1), 32'd16);

    // every code once on the STEP=4 instance, visited in a scrambled order
    for (int k = 0; k < 32; k++) begin
      sel = 1'b1;
      #1;
      st = c4;
      v.sel = 1'b1;
      v.code = 5'((k * 13) % 32);
      v.hold_after = -1;
      v.hold_len = 0;
      v.noise = 5'd0;
      dd = int'(v.code) - int'(st);
      if (dd < 0) dd = -dd;
      v.exp_edges = (dd + 3) / 4;
      v.exp_therm = (v.code == 5'd0) ? 32'h0 : (32'hFFFF_FFFF >> (32 - int'(v.code)));
      run_move(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
